// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding,
// default qualification length and counter width derivation.
package btn_pkg;

  // Per-channel qualification FSM states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMING    = 2'd1,
    ST_PRESSED   = 2'd2,
    ST_RELEASING = 2'd3
  } btn_state_e;

  // 10 ms of stable samples at 100 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

  // Smallest counter width that can hold DEBOUNCE_CYCLES-1 without wrapping.
  // Never narrower than one bit so tiny simulation values still elaborate.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

  localparam int DEFAULT_NB_CNT = cnt_width(DEFAULT_DEBOUNCE_CYCLES);

endpackage

// File: rtl/debounce_cell.sv
// One button channel: two-flop synchroniser, four-state qualification FSM
// with its stability counter, registered debounced level and press pulse.
module debounce_cell
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int NB_CNT          = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_btn_level,
  output logic o_btn_pulse
);

  // Terminal count: DEBOUNCE_CYCLES-1 further stable samples after entry
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);
  localparam logic [NB_CNT-1:0] CNT_ONE  = NB_CNT'(1);

  logic              sync_meta_q;
  logic              sync_q;
  btn_state_e        state_q;
  btn_state_e        state_d;
  logic [NB_CNT-1:0] cnt_q;
  logic [NB_CNT-1:0] cnt_d;
  logic              level_q;
  logic              level_d;
  logic              pulse_q;
  logic              pulse_d;
  logic              cnt_done;

  // Two back-to-back flops bring the asynchronous button into the clock domain
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      sync_meta_q <= i_btn;
      sync_q      <= sync_meta_q;
    end
  end

  assign cnt_done = (cnt_q == CNT_LAST);

  // Next-state, counter and output decode; the counter restarts on every state entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sync_q) begin
          state_d = ST_ARMING;
          cnt_d   = '0;
        end
      end

      ST_ARMING: begin
        if (!sync_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_PRESSED: begin
        if (!sync_q) begin
          state_d = ST_RELEASING;
          cnt_d   = '0;
        end
      end

      ST_RELEASING: begin
        if (sync_q) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASING);
  end

  // State, counter and both outputs update together so level and pulse align
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign o_btn_level = level_q;
  assign o_btn_pulse = pulse_q;

endmodule

// File: rtl/btn_debouncer.sv
// Debounces NB_BTN independent push-buttons; each channel yields a stable
// level and a one-cycle pulse per accepted press for the load enables.
module btn_debouncer
  import btn_pkg::*;
#(
  parameter int NB_BTN          = 3,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int NB_CNT          = DEFAULT_NB_CNT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NB_BTN-1:0] i_btn,
  output logic [NB_BTN-1:0] o_btn_level,
  output logic [NB_BTN-1:0] o_btn_pulse
);

  // Channels share nothing but clock and reset
  for (genvar g = 0; g < NB_BTN; g++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .NB_CNT          (NB_CNT)
    ) u_cell (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_btn       (i_btn[g]),
      .o_btn_level (o_btn_level[g]),
      .o_btn_pulse (o_btn_pulse[g])
    );
  end

endmodule

// File: tb/tb_btn_debouncer.sv
// Self-checking bench for btn_debouncer with a short qualification length.
`timescale 1ns/1ps
module tb_btn_debouncer;

  localparam int NB_BTN = 3;
  localparam int DEB    = 4;
  localparam int NB_CNT = 2;

  logic              i_clk;
  logic              i_reset;
  logic [NB_BTN-1:0] i_btn;
  logic [NB_BTN-1:0] o_btn_level;
  logic [NB_BTN-1:0] o_btn_pulse;

  int checkCount;
  int errorCount;
  int edgeNum;
  int pulseCnt [NB_BTN];
  int pulseBase [NB_BTN];

  logic [NB_BTN-1:0] levelModel;
  logic [NB_BTN-1:0] pulseModel;
  int                runLen [NB_BTN];
  logic [NB_BTN-1:0] sampleHist [$];

  btn_debouncer #(
    .NB_BTN          (NB_BTN),
    .DEBOUNCE_CYCLES (DEB),
    .NB_CNT          (NB_CNT)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_btn       (i_btn),
    .o_btn_level (o_btn_level),
    .o_btn_pulse (o_btn_pulse)
  );

  // 100 MHz clock
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Edge numbering restarts meaning after reset: edge 1 is the first one out of reset
  always @(posedge i_clk) begin
    if (!i_reset) begin
      edgeNum <= edgeNum + 1;
    end
  end

  // Pulses seen per channel, sampled mid-cycle
  always @(negedge i_clk) begin
    for (int c = 0; c < NB_BTN; c++) begin
      if (o_btn_pulse[c]) begin
        pulseCnt[c] <= pulseCnt[c] + 1;
      end
    end
  end

  // Behavioural model: a channel's level flips once the value it sees has
  // differed from the current level for DEB+1 consecutive samples; what a
  // channel sees is the raw input two edges late. A rising flip is a press.
  always @(posedge i_clk or posedge i_reset) begin : modelBlk
    logic [NB_BTN-1:0] seen;
    if (i_reset) begin
      levelModel = '0;
      pulseModel = '0;
      sampleHist.delete();
      for (int c = 0; c < NB_BTN; c++) runLen[c] = 0;
    end else begin
      sampleHist.push_back(i_btn);
      if (sampleHist.size() > 3) void'(sampleHist.pop_front());
      seen = (sampleHist.size() == 3) ? sampleHist[0] : '0;
      pulseModel = '0;
      for (int c = 0; c < NB_BTN; c++) begin
        if (seen[c] != levelModel[c]) runLen[c] = runLen[c] + 1;
        else runLen[c] = 0;
        if (runLen[c] == DEB + 1) begin
          levelModel[c] = seen[c];
          pulseModel[c] = seen[c];
          runLen[c]     = 0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NB_BTN-1:0] value, input int cycles);
    i_btn = value;
    repeat (cycles) @(negedge i_clk);
  endtask

  task automatic waitToEdge(input int n);
    while (edgeNum < n) @(negedge i_clk);
  endtask

  task automatic snapPulses();
    for (int c = 0; c < NB_BTN; c++) pulseBase[c] = pulseCnt[c];
  endtask

  // Model-versus-DUT comparison on every cycle
  always @(negedge i_clk) begin
    checkOutput("model_level", int'(o_btn_level), int'(levelModel));
    checkOutput("model_pulse", int'(o_btn_pulse), int'(pulseModel));
  end

  // Watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errorCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_reset = 1'b1;
    i_btn   = '0;
    repeat (3) @(negedge i_clk);
    checkOutput("reset_level", int'(o_btn_level), 0);
    checkOutput("reset_pulse", int'(o_btn_pulse), 0);
    i_reset = 1'b0;
    snapPulses();

    // Clean press on channel 0, first sampled at edge 10, held 20 cycles
    $display("[TB] clean press");
    waitToEdge(9);
    applyStimulus(3'b001, 1);
    waitToEdge(15);
    checkOutput("clean_pulse_e15", int'(o_btn_pulse), 0);
    checkOutput("clean_level_e15", int'(o_btn_level), 0);
    waitToEdge(16);
    checkOutput("clean_pulse_e16", int'(o_btn_pulse), 1);
    checkOutput("clean_level_e16", int'(o_btn_level), 1);
    waitToEdge(17);
    checkOutput("clean_pulse_e17", int'(o_btn_pulse), 0);
    checkOutput("clean_level_e17", int'(o_btn_level), 1);
    waitToEdge(29);
    applyStimulus(3'b000, 1);
    waitToEdge(35);
    checkOutput("clean_rel_e35", int'(o_btn_level), 1);
    waitToEdge(36);
    checkOutput("clean_rel_e36", int'(o_btn_level), 0);
    checkOutput("clean_pulse_cnt", pulseCnt[0] - pulseBase[0], 1);

    // Bouncy press on channel 1: 1,0,1,1,0,1 then held; final run starts at edge 46
    $display("[TB] bouncy press");
    waitToEdge(40);
    snapPulses();
    begin
      logic [5:0] bouncePat;
      bouncePat = 6'b101101;
      for (int i = 5; i >= 0; i--) applyStimulus({1'b0, bouncePat[i], 1'b0}, 1);
    end
    waitToEdge(51);
    checkOutput("bounce_pulse_e51", int'(o_btn_pulse), 0);
    waitToEdge(52);
    checkOutput("bounce_pulse_e52", int'(o_btn_pulse), 2);
    checkOutput("bounce_level_e52", int'(o_btn_level), 2);
    waitToEdge(60);
    checkOutput("bounce_pulse_cnt", pulseCnt[1] - pulseBase[1], 1);
    applyStimulus(3'b000, 1);

    // Release glitch on channel 2, then a true release sampled from edge 96
    $display("[TB] release glitch");
    waitToEdge(70);
    snapPulses();
    applyStimulus(3'b100, 1);
    waitToEdge(80);
    checkOutput("glitch_level_pre", int'(o_btn_level), 4);
    applyStimulus(3'b000, 2);
    applyStimulus(3'b100, 1);
    waitToEdge(95);
    checkOutput("glitch_level_post", int'(o_btn_level), 4);
    checkOutput("glitch_pulse_cnt", pulseCnt[2] - pulseBase[2], 1);
    applyStimulus(3'b000, 1);
    waitToEdge(101);
    checkOutput("glitch_rel_e101", int'(o_btn_level), 4);
    waitToEdge(102);
    checkOutput("glitch_rel_e102", int'(o_btn_level), 0);

    // Simultaneous press on all channels, first sampled at edge 111
    $display("[TB] simultaneous press");
    waitToEdge(110);
    applyStimulus(3'b111, 1);
    waitToEdge(116);
    checkOutput("simul_pulse_e116", int'(o_btn_pulse), 0);
    waitToEdge(117);
    checkOutput("simul_pulse_e117", int'(o_btn_pulse), 7);
    waitToEdge(118);
    checkOutput("simul_pulse_e118", int'(o_btn_pulse), 0);
    checkOutput("simul_level_e118", int'(o_btn_level), 7);
    applyStimulus(3'b000, 1);

    // Reset while channel 0 is in ARMING, button still held afterwards
    $display("[TB] reset mid-arming");
    waitToEdge(130);
    applyStimulus(3'b001, 1);
    waitToEdge(135);
    snapPulses();
    #2;
    i_reset = 1'b1;
    #1;
    checkOutput("rst_async_level", int'(o_btn_level), 0);
    checkOutput("rst_async_pulse", int'(o_btn_pulse), 0);
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    checkOutput("rst_no_pulse", pulseCnt[0] - pulseBase[0], 0);
    waitToEdge(141);
    checkOutput("rst_pulse_e141", int'(o_btn_pulse), 0);
    checkOutput("rst_level_e141", int'(o_btn_level), 0);
    waitToEdge(142);
    checkOutput("rst_pulse_e142", int'(o_btn_pulse), 1);
    checkOutput("rst_level_e142", int'(o_btn_level), 1);

    // Long hold of channel 0 for 200 more cycles
    $display("[TB] long hold");
    waitToEdge(342);
    checkOutput("hold_level", int'(o_btn_level), 1);
    checkOutput("hold_pulse_cnt", pulseCnt[0] - pulseBase[0], 1);
    applyStimulus(3'b000, 1);
    waitToEdge(355);
    checkOutput("final_level", int'(o_btn_level), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
